// File: rtl/ara_perf_window_cnt.sv
// Windowed performance counters for the vector unit: cycle and event counting, snapshots, overflow.
// Build option ARA_PERF_CNT_SATURATE_EN: counters hold at all-ones instead of wrapping.
module ara_perf_window_cnt #(
    parameter int unsigned NrEvents = 3,
    parameter int unsigned CntWidth = 64
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               sw_en_i,
    input  logic                               start_i,
    input  logic                               idle_i,
    input  logic                               clear_i,
    input  logic [NrEvents-1:0]                event_i,
    output logic                               counting_o,
    output logic [CntWidth-1:0]                cycles_o,
    output logic [NrEvents-1:0][CntWidth-1:0]  evt_cnt_o,
    output logic [CntWidth-1:0]                snap_cycles_o,
    output logic [NrEvents-1:0][CntWidth-1:0]  snap_evt_o,
    output logic                               snap_valid_o,
    output logic [NrEvents:0]                  ovf_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    localparam logic [CntWidth-1:0] CntMax = '1;
    localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

    logic [1:0]                         state_q, state_d;
    logic [CntWidth-1:0]                cyc_q, cyc_d;
    logic [NrEvents-1:0][CntWidth-1:0]  evt_q, evt_d;
    logic [CntWidth-1:0]                snap_cyc_q;
    logic [NrEvents-1:0][CntWidth-1:0]  snap_evt_q;
    logic                               pending_q, pending_d;
    logic                               snap_valid_q;
    logic [NrEvents:0]                  ovf_q, ovf_d;
    logic                               counting;
    logic                               snap_fire;

    function automatic logic [CntWidth-1:0] bump(input logic [CntWidth-1:0] v);
`ifdef ARA_PERF_CNT_SATURATE_EN
        return (v == CntMax) ? v : v + CntOne;
`else
        return v + CntOne;
`endif
    endfunction

    assign counting  = (state_q != StIdle);
    // A start in the same cycle keeps the window pending and blocks the snapshot.
    assign snap_fire = pending_q & idle_i & ~start_i;
    assign pending_d = start_i | (pending_q & ~snap_fire);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (sw_en_i && start_i) state_d = StRun;
            end
            StRun: begin
                if (!sw_en_i) state_d = idle_i ? StIdle : StDrain;
            end
            StDrain: begin
                if (sw_en_i)     state_d = StRun;
                else if (idle_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cyc_d = cyc_q;
        evt_d = evt_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            cyc_d = '0;
            evt_d = '0;
            ovf_d = '0;
        end else if (counting) begin
            if (cyc_q == CntMax) ovf_d[0] = 1'b1;
            cyc_d = bump(cyc_q);
            for (int unsigned i = 0; i < NrEvents; i++) begin
                if (event_i[i]) begin
                    if (evt_q[i] == CntMax) ovf_d[i+1] = 1'b1;
                    evt_d[i] = bump(evt_q[i]);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cyc_q        <= '0;
            evt_q        <= '0;
            snap_cyc_q   <= '0;
            snap_evt_q   <= '0;
            pending_q    <= 1'b0;
            snap_valid_q <= 1'b0;
            ovf_q        <= '0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            evt_q        <= evt_d;
            pending_q    <= pending_d;
            snap_valid_q <= snap_fire;
            ovf_q        <= ovf_d;
            if (snap_fire) begin
                snap_cyc_q <= cyc_q;
                snap_evt_q <= evt_q;
            end
        end
    end

    assign counting_o    = counting;
    assign cycles_o      = cyc_q;
    assign evt_cnt_o     = evt_q;
    assign snap_cycles_o = snap_cyc_q;
    assign snap_evt_o    = snap_evt_q;
    assign snap_valid_o  = snap_valid_q;
    assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_ara_perf_window_cnt.sv
// Scoreboard bench for ara_perf_window_cnt (3 channels, 8-bit counters).
// Predictions come from a cycle-level model of the window rules.
module tb_ara_perf_window_cnt;

    localparam int NE = 3;
    localparam int CW = 8;

    logic                    clk = 1'b0;
    logic                    rst_ni = 1'b0;
    logic                    sw_en_i = 1'b0;
    logic                    start_i = 1'b0;
    logic                    idle_i = 1'b1;
    logic                    clear_i = 1'b0;
    logic [NE-1:0]           event_i = '0;
    logic                    counting_o;
    logic [CW-1:0]           cycles_o;
    logic [NE-1:0][CW-1:0]   evt_cnt_o;
    logic [CW-1:0]           snap_cycles_o;
    logic [NE-1:0][CW-1:0]   snap_evt_o;
    logic                    snap_valid_o;
    logic [NE:0]             ovf_o;

    ara_perf_window_cnt #(.NrEvents(NE), .CntWidth(CW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .sw_en_i(sw_en_i),
        .start_i(start_i), .idle_i(idle_i), .clear_i(clear_i),
        .event_i(event_i), .counting_o(counting_o),
        .cycles_o(cycles_o), .evt_cnt_o(evt_cnt_o),
        .snap_cycles_o(snap_cycles_o), .snap_evt_o(snap_evt_o),
        .snap_valid_o(snap_valid_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                  cnt;
        logic [CW-1:0]         cyc;
        logic [NE-1:0][CW-1:0] evt;
        logic [CW-1:0]         scyc;
        logic [NE-1:0][CW-1:0] sevt;
        logic                  sv;
        logic [NE:0]           ovf;
    } obs_t;

    typedef struct packed {
        logic [CW-1:0]         cyc;
        logic [NE-1:0][CW-1:0] evt;
    } snap_t;

    obs_t  exp_q[$];
    snap_t snap_q[$];
    int    errors = 0;
    int    checks = 0;

    // Reference model: 0 = idle, 1 = run, 2 = drain
    int m_mode = 0;
    int m_cyc = 0;
    int m_ev[NE];
    int m_scyc = 0;
    int m_sev[NE];
    bit m_pend = 0;
    bit m_sv = 0;
    bit m_ovf[NE+1];

    function automatic int inc(int v);
`ifdef ARA_PERF_CNT_SATURATE_EN
        return (v == 255) ? 255 : v + 1;
`else
        return (v + 1) % 256;
`endif
    endfunction

    task automatic step(input bit rst, input bit en, input bit st,
                        input bit idl, input bit clr,
                        input bit [NE-1:0] ev);
        obs_t  o;
        snap_t s;
        bit    win;
        bit    take;
        rst_ni = rst; sw_en_i = en; start_i = st;
        idle_i = idl; clear_i = clr; event_i = ev;
        if (!rst) begin
            m_mode = 0; m_cyc = 0; m_scyc = 0;
            m_pend = 0; m_sv = 0;
            for (int i = 0; i < NE; i++) begin
                m_ev[i] = 0; m_sev[i] = 0;
            end
            for (int i = 0; i <= NE; i++) m_ovf[i] = 0;
        end else begin
            win  = (m_mode != 0);
            take = m_pend && idl && !st;
            if (take) begin
                m_scyc = m_cyc;
                for (int i = 0; i < NE; i++) m_sev[i] = m_ev[i];
                s.cyc = m_cyc[CW-1:0];
                for (int i = 0; i < NE; i++) s.evt[i] = m_ev[i][CW-1:0];
                snap_q.push_back(s);
            end
            m_sv = take;
            if (st) m_pend = 1;
            else if (take) m_pend = 0;
            if (clr) begin
                m_cyc = 0;
                for (int i = 0; i < NE; i++) m_ev[i] = 0;
                for (int i = 0; i <= NE; i++) m_ovf[i] = 0;
            end else if (win) begin
                if (m_cyc == 255) m_ovf[0] = 1;
                m_cyc = inc(m_cyc);
                for (int i = 0; i < NE; i++) if (ev[i]) begin
                    if (m_ev[i] == 255) m_ovf[i+1] = 1;
                    m_ev[i] = inc(m_ev[i]);
                end
            end
            case (m_mode)
                0: if (en && st) m_mode = 1;
                1: if (!en) m_mode = idl ? 0 : 2;
                default: begin
                    if (en) m_mode = 1;
                    else if (idl) m_mode = 0;
                end
            endcase
        end
        o.cnt  = (m_mode != 0);
        o.cyc  = m_cyc[CW-1:0];
        o.scyc = m_scyc[CW-1:0];
        for (int i = 0; i < NE; i++) begin
            o.evt[i]  = m_ev[i][CW-1:0];
            o.sevt[i] = m_sev[i][CW-1:0];
        end
        o.sv = m_sv;
        for (int i = 0; i <= NE; i++) o.ovf[i] = m_ovf[i];
        exp_q.push_back(o);
    endtask

    task automatic c(input bit rst, input bit en, input bit st,
                     input bit idl, input bit clr,
                     input bit [NE-1:0] ev);
        @(negedge clk);
        #1;
        step(rst, en, st, idl, clr, ev);
    endtask

    // Monitor: compares every presented cycle, and each snapshot pulse
    initial begin
        obs_t  e, a;
        snap_t se, sa;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {counting_o, cycles_o, evt_cnt_o, snap_cycles_o,
                     snap_evt_o, snap_valid_o, ovf_o};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL live t=%0t got cnt=%b cyc=%0d evt=%h scyc=%0d sevt=%h sv=%b ovf=%b want cnt=%b cyc=%0d evt=%h scyc=%0d sevt=%h sv=%b ovf=%b",
                             $time, a.cnt, a.cyc, a.evt, a.scyc, a.sevt,
                             a.sv, a.ovf, e.cnt, e.cyc, e.evt, e.scyc,
                             e.sevt, e.sv, e.ovf);
                end
            end
            if (snap_valid_o === 1'b1) begin
                checks++;
                if (snap_q.size() == 0) begin
                    errors++;
                    $display("FAIL snap t=%0t unexpected pulse got cyc=%0d evt=%h want none",
                             $time, snap_cycles_o, snap_evt_o);
                end else begin
                    se = snap_q.pop_front();
                    sa = {snap_cycles_o, snap_evt_o};
                    if (sa !== se) begin
                        errors++;
                        $display("FAIL snap t=%0t got cyc=%0d evt=%h want cyc=%0d evt=%h",
                                 $time, sa.cyc, sa.evt, se.cyc, se.evt);
                    end
                end
            end
        end
    end

    initial begin
        int pclr;
        bit en;
        for (int i = 0; i < NE; i++) begin
            m_ev[i] = 0; m_sev[i] = 0;
        end
        for (int i = 0; i <= NE; i++) m_ovf[i] = 0;

        repeat (3) c(0, 0, 0, 1, 0, 3'b000);
        repeat (7) c(1, 1, 0, 1, 0, 3'b000);
        // window opened by start, busy 20 cycles, then idle snapshot
        c(1, 1, 1, 0, 0, 3'b000);
        repeat (19) c(1, 1, 0, 0, 0, 3'b000);
        c(1, 1, 0, 1, 0, 3'b000);
        repeat (7) c(1, 1, 0, 1, 0, 3'b101);
        repeat (260) c(1, 1, 0, 1, 0, 3'($urandom));
        c(1, 1, 0, 1, 1, 3'b111);
        repeat (5) c(1, 0, 0, 0, 0, 3'b010);
        c(1, 0, 0, 1, 0, 3'b000);
        repeat (3) c(1, 0, 0, 1, 0, 3'b111);
        // start and idle together with pending set, then start drops
        c(1, 1, 1, 0, 0, 3'b000);
        c(1, 1, 1, 1, 0, 3'b000);
        c(1, 1, 0, 1, 0, 3'b001);
        repeat (48) c(1, 1, 0, 0, 0, 3'b011);
        c(0, 1, 0, 0, 0, 3'b011);
        c(1, 1, 1, 0, 0, 3'b000);
        repeat (4) c(1, 1, 0, 1, 0, 3'b100);

        en = 1'b1;
        for (int seg = 0; seg < 40; seg++) begin
            pclr = (seg % 3 == 0) ? 3 : 0;
            if ($urandom_range(0, 2) == 0) en = ~en;
            for (int k = 0; k < 100; k++) begin
                c(($urandom_range(0, 399) != 0),
                  ($urandom_range(0, 9) == 0) ? ~en : en,
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 99) < pclr),
                  3'($urandom));
            end
        end

        repeat (3) @(negedge clk);
        checks++;
        if (snap_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got snaps_left=%0d obs_left=%0d want 0 and 0",
                     snap_q.size(), exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
